// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the instruction fetch stage
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_BYTES   = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : small synchronous FIFO of fetch entries with flush
// Revision    : 1.0
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enq,
  input  logic         deq,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;

  // Entries are cleared on reset so the head reads as zero before any fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (enq) begin
        r_mem[r_wr] <= wdata;
        r_wr        <= r_wr + 1'b1;
      end
      if (deq) begin
        r_rd <= r_rd + 1'b1;
      end
      if (enq && !deq) begin
        r_count <= r_count + 1'b1;
      end else if (deq && !enq) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd];

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : PC owner, captures same-cycle imem word, hands pairs to decode
// Revision    : 1.0
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  logic [31:0]  r_pc;
  logic         w_full;
  logic         w_empty;
  logic         w_enq;
  logic         w_deq;
  fetch_entry_t w_wdata;
  fetch_entry_t w_head;

  // Redirect suppresses both sides of the queue; out_ready never feeds out_valid.
  assign out_valid = !w_empty && !redirect_valid;
  assign w_deq     = out_valid && out_ready;
  assign w_enq     = !redirect_valid && (!w_full || w_deq);

  assign w_wdata.pc    = r_pc;
  assign w_wdata.instr = imem_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc & PC_ALIGN_MASK;
    end else if (w_enq) begin
      r_pc <= r_pc + INSTR_BYTES;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .enq   (w_enq),
    .deq   (w_deq),
    .flush (redirect_valid),
    .wdata (w_wdata),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign imem_addr = r_pc;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : scoreboard bench for fetch_stage (memory word n holds n)
// Revision       : 1.0
// ============================================================================
module tb_fetch_stage;

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        out_ready      = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pops  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign imem_instr = {2'b00, imem_addr[31:2]};

  fetch_stage #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected delivery order restarts at every reset release or redirect.
  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(start + 32'(i * 4));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : b_monitor
    logic [31:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_instr", out_instr, {2'b00, e[31:2]});
      end
      n_pops++;
    end
  end

  initial begin : b_main
    int          p0;
    logic [31:0] e0;

    #2;
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);

    // Release reset and stream with decode always ready
    tick();
    restart_stream(32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("valid_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("valid_cycle2", 32'(out_valid), 32'd1);
    tick();
    repeat (3) tick();

    // Stall decode until the queue saturates
    out_ready = 1'b0;
    e0        = exp_q[0];
    repeat (5) tick();
    check("stall_addr", imem_addr, e0 + 32'd8);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_pc", out_pc, e0);
    p0        = n_pops;
    out_ready = 1'b1;
    repeat (4) tick();
    check("release_pops", 32'(n_pops - p0), 32'd4);

    // Redirect while full, unaligned target
    out_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    out_ready      = 1'b1;
    restart_stream(32'h0000_0100);
    @(negedge clk);
    check("redir_full_valid", 32'(out_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check("redir_addr", imem_addr, 32'h0000_0100);
    check("redir_n1_valid", 32'(out_valid), 32'd0);
    tick();
    check("redir_n2_valid", 32'(out_valid), 32'd1);
    check("redir_n2_pc", out_pc, 32'h0000_0100);
    repeat (3) tick();

    // Redirect during steady streaming (one entry held, decode ready)
    check("pre_redir_valid", 32'(out_valid), 32'd1);
    p0             = n_pops;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    restart_stream(32'h0000_0040);
    @(negedge clk);
    check("redir_drop_valid", 32'(out_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check("redir_drop_pops", 32'(n_pops - p0), 32'd0);
    repeat (4) tick();

    // Redirect near the top of the address space: PC wraps to zero
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    restart_stream(32'hFFFF_FFF8);
    tick();
    redirect_valid = 1'b0;
    p0             = n_pops;
    repeat (5) tick();
    check("wrap_pops", 32'(n_pops - p0), 32'd4);

    // Asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_addr", imem_addr, 32'h0);
    check("async_pc", out_pc, 32'h0);
    check("async_instr", out_instr, 32'h0);
    exp_q.delete();
    tick();
    tick();
    restart_stream(32'h0);
    rst_n = 1'b1;
    p0    = n_pops;
    repeat (5) tick();
    check("post_rst_pops", 32'(n_pops - p0), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the instruction memory and directly feeds decode. It owns the program counter and drives the memory address. It captures the same-cycle combinational instruction word into a small buffer. It presents PC/instruction pairs to decode over a valid/ready handshake, and restarts at a new PC on a redirect from execute.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- QUEUE_DEPTH, 2, fetch buffer entries; power of two, ≥ 2

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset
- Clock/reset: one clock; reset is asynchronous and active-low
- redirect_valid  in  1  restart fetch at redirect_pc this cycle
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0)
- imem_addr  out  32  byte address to instruction memory, equals current PC
- imem_instr  in  32  instruction word returned combinationally for imem_addr in the same cycle
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode accepts head entry
- out_pc  out  32  PC of head entry
- out_instr  out  32  instruction of head entry

## Operation
- State:
  - pc register (32b)
  - queue of QUEUE_DEPTH entries {pc, instr}
  - read and write pointers of $clog2(QUEUE_DEPTH) bits
  - count of $clog2(QUEUE_DEPTH+1) bits
- imem_addr = pc, combinational from the register.
- Dequeue condition (deq): out_valid & out_ready.
- out_valid = (count != 0) & ~redirect_valid. No transfer occurs in a redirect cycle.
- Enqueue condition (enq): ~redirect_valid & ((count < QUEUE_DEPTH) | deq).
  - On enq: queue[wr] <= {pc, imem_instr}; wr++; pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Simultaneous enq and deq: count unchanged, both pointers advance. This holds even when full.
- Full with no deq: pc holds; imem_addr is stable until space frees.
- Redirect, which has priority over everything:
  - pc <= {redirect_pc[31:2], 2'b00}
  - count <= 0, rd <= 0, wr <= 0
  - nothing is enqueued or dequeued that cycle
- Back-to-back redirects: each one overrides the previous; the last one wins.
- out_pc / out_instr = queue[rd] whenever count != 0; don't-care when out_valid = 0, but must be deterministic.

## Timing
- Reset values:
  - pc = RESET_PC, so imem_addr = RESET_PC
  - count = 0, pointers = 0
  - out_valid = 0
  - out_pc = 0 and out_instr = 0 (all queue entries cleared)
- Reset assertion mid-operation takes effect immediately (async). Outputs return to reset values without a clock edge.
- Latency: the instruction at PC X is enqueued on the edge ending the cycle where imem_addr = X. out_valid rises 1 cycle later (if the queue was empty).
- Redirect latency:
  - Cycle N: redirect_valid sampled.
  - Cycle N+1: imem_addr = target.
  - Cycle N+2: earliest out_valid with out_pc = target.
- Sustained throughput: 1 instruction/cycle while out_ready = 1.
- Combinational paths: redirect_valid → out_valid only. No path from out_ready to out_valid.

## Structure
- Package fetch_pkg:
  - fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr;}
  - INSTR_BYTES = 4
  - PC_ALIGN_MASK = 32'hFFFF_FFFC
- Sub-module fetch_queue, a parameterised synchronous FIFO of fetch_entry_t:
  - inputs: enq, deq, flush
  - outputs: full, empty, head
  - async active-low reset
- fetch_stage instantiates fetch_queue and holds only pc and the enq/deq/redirect control.

## Test plan
- Reset release with RESET_PC = 0, out_ready = 1, memory word n = n: out_pc sequence 0, 4, 8, … and out_instr 0, 1, 2, …; out_valid first high on the 2nd cycle after reset release.
- Hold out_ready = 0 for 5 cycles: count saturates at 2; imem_addr stalls at 8; queue holds PCs 0 and 4. Release → 0, 4, 8 delivered with no gap or duplicate.
- Redirect to 32'h0000_0103 while the queue holds 2 entries: out_valid = 0 that cycle; next out_pc = 32'h0000_0100 two cycles later; the old entries are never delivered.
- Redirect to 32'h0000_0040 in the same cycle as out_ready = 1 with count = 1: no handshake counted; that entry is dropped.
- Redirect to 32'hFFFF_FFF8 with out_ready = 1: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst_n = 0 asynchronously mid-stream, between clock edges: out_valid drops immediately and imem_addr = RESET_PC. After release, fetch resumes from RESET_PC.
